// File: rtl/glitch_filter_multi_if.sv
// Signal bundle for glitch_filter_multi: control and raw inputs in, filtered levels and strobes out.
interface glitch_filter_multi_if #(
    parameter int unsigned CH = 4
);
    logic          en;
    logic          mode;
    logic [CH-1:0] x_in;
    logic [CH-1:0] y_out;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] unstable;

    modport master (output en, mode, x_in, input y_out, rise, fall, unstable);
    modport slave  (input en, mode, x_in, output y_out, rise, fall, unstable);
endinterface

// File: rtl/glitch_filter_multi.sv
// Multi-channel deglitcher: 2-flop sync, DEPTH-sample history, unanimous or majority decision,
// registered level with one-cycle rise/fall strobes and an instability flag.
module glitch_filter_multi #(
    parameter int unsigned CH    = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 cp,
    input  logic                 rst,
    glitch_filter_multi_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned DW = CW + 1;

    logic [CH-1:0]            r_s1;
    logic [CH-1:0]            r_s2;
    logic [CH-1:0][DEPTH-1:0] r_h;
    logic [CH-1:0]            r_y;
    logic [CH-1:0]            r_rise;
    logic [CH-1:0]            r_fall;
    logic [CH-1:0]            r_unst;

    logic [CH-1:0][CW-1:0]    w_ones;
    logic [CH-1:0][DW-1:0]    w_dbl;
    logic [CH-1:0]            w_all1;
    logic [CH-1:0]            w_all0;
    logic [CH-1:0]            w_y;

    // Decision is taken from the history as registered before the edge; undecided rules hold.
    always_comb begin
        for (int c = 0; c < int'(CH); c++) begin
            w_ones[c] = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                w_ones[c] = w_ones[c] + CW'(r_h[c][i]);
            end
            w_dbl[c]  = {w_ones[c], 1'b0};
            w_all1[c] = &r_h[c];
            w_all0[c] = ~|r_h[c];
            w_y[c]    = r_y[c];
            if (!bus.mode) begin
                if (w_all1[c]) begin
                    w_y[c] = 1'b1;
                end else if (w_all0[c]) begin
                    w_y[c] = 1'b0;
                end
            end else begin
                if (w_dbl[c] > DW'(DEPTH)) begin
                    w_y[c] = 1'b1;
                end else if (w_dbl[c] < DW'(DEPTH)) begin
                    w_y[c] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_h    <= '0;
            r_y    <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_unst <= '0;
        end else begin
            r_s1 <= bus.x_in;
            r_s2 <= r_s1;
            if (bus.en) begin
                for (int c = 0; c < int'(CH); c++) begin
                    r_h[c] <= {r_h[c][DEPTH-2:0], r_s2[c]};
                end
                r_y    <= w_y;
                r_rise <= w_y & ~r_y;
                r_fall <= ~w_y & r_y;
                r_unst <= ~(w_all1 | w_all0);
            end else begin
                r_rise <= '0;
                r_fall <= '0;
            end
        end
    end

    assign bus.y_out    = r_y;
    assign bus.rise     = r_rise;
    assign bus.fall     = r_fall;
    assign bus.unstable = r_unst;
endmodule

// File: tb/tb_glitch_filter_multi.sv
// Self-checking bench for glitch_filter_multi: vector table, directed corner sequences and
// randomized stimulus against a queue-based behavioural model.
module tb_glitch_filter_multi;
    localparam int unsigned CH    = 4;
    localparam int unsigned DEPTH = 4;

    logic cp  = 1'b0;
    logic rst = 1'b1;

    glitch_filter_multi_if #(.CH(CH)) bus ();

    glitch_filter_multi #(
        .CH    (CH),
        .DEPTH (DEPTH)
    ) dut (
        .cp  (cp),
        .rst (rst),
        .bus (bus)
    );

    always #5 cp = ~cp;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: sync delay as two vectors, history as per-channel queues (front = newest).
    logic [CH-1:0] m_s1, m_s2, m_y, m_rise, m_fall, m_unst;
    bit            m_h [CH][$];

    typedef struct {
        logic [CH-1:0] x;
        logic [CH-1:0] y;
        logic [CH-1:0] r;
        logic [CH-1:0] f;
        logic [CH-1:0] u;
    } vec_t;

    vec_t tbl [10];

    task automatic model_reset();
        for (int c = 0; c < int'(CH); c++) begin
            m_h[c].delete();
            for (int i = 0; i < int'(DEPTH); i++) m_h[c].push_back(1'b0);
        end
        m_s1 = '0; m_s2 = '0; m_y = '0; m_rise = '0; m_fall = '0; m_unst = '0;
    endtask

    task automatic model_edge(input logic en_v, input logic mode_v, input logic [CH-1:0] x_v);
        for (int c = 0; c < int'(CH); c++) begin
            int   ones;
            logic y;
            ones = 0;
            for (int i = 0; i < m_h[c].size(); i++) ones += int'(m_h[c][i]);
            if (en_v) begin
                y = m_y[c];
                if (!mode_v) begin
                    if (ones == int'(DEPTH)) y = 1'b1;
                    else if (ones == 0)      y = 1'b0;
                end else begin
                    if (2 * ones > int'(DEPTH))      y = 1'b1;
                    else if (2 * ones < int'(DEPTH)) y = 1'b0;
                end
                m_rise[c] = y & ~m_y[c];
                m_fall[c] = ~y & m_y[c];
                m_y[c]    = y;
                m_unst[c] = (ones != 0) && (ones != int'(DEPTH));
                m_h[c].push_front(m_s2[c]);
                void'(m_h[c].pop_back());
            end else begin
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
            end
        end
        m_s2 = m_s1;
        m_s1 = x_v;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] outs();
        return {bus.y_out, bus.rise, bus.fall, bus.unstable};
    endfunction

    // One clock: model follows the inputs present at the edge; outputs compared on the falling edge.
    task automatic step(input string name);
        logic          en_v, mode_v;
        logic [CH-1:0] x_v;
        en_v = bus.en; mode_v = bus.mode; x_v = bus.x_in;
        @(posedge cp);
        if (rst) model_reset();
        else     model_edge(en_v, mode_v, x_v);
        @(negedge cp);
        chk(name, outs(), {m_y, m_rise, m_fall, m_unst});
        chk("excl", 16'(bus.rise & bus.fall), 16'(0));
    endtask

    initial begin
        bit found;
        bus.en = 1'b1; bus.mode = 1'b0; bus.x_in = '0;
        model_reset();

        tbl[0] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[1] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[2] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[3] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0011};
        tbl[4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0011};
        tbl[5] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0011};
        tbl[6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
        tbl[7] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010};
        tbl[8] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010};
        tbl[9] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};

        #1 chk("reset_state", outs(), 16'(0));
        step("in_reset");
        step("in_reset");
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step("idle");
            chk("idle_zero", outs(), 16'(0));
        end

        // Unanimous: ch0 step and ch1 3-sample pulse launched at the same edge.
        for (int i = 0; i < 10; i++) begin
            bus.x_in = tbl[i].x;
            step("table_model");
            chk($sformatf("table_row%0d", i), outs(), {tbl[i].y, tbl[i].r, tbl[i].f, tbl[i].u});
        end

        // Majority: same 3-sample pulse on ch1 now passes.
        bus.mode = 1'b1;
        for (int j = 0; j < 12; j++) begin
            bus.x_in[1] = (j < 3);
            step("maj3");
            if (j == 5) chk("maj3_rise", 16'({bus.y_out[1], bus.rise[1]}), 16'(2'b11));
            if (j == 8) chk("maj3_fall", 16'({bus.y_out[1], bus.fall[1]}), 16'(2'b01));
        end

        // Majority tie: 2-sample pulse on ch2 must be held off.
        for (int j = 0; j < 12; j++) begin
            bus.x_in[2] = (j < 2);
            step("tie");
            chk("tie_ch2", 16'({bus.y_out[2], bus.rise[2], bus.fall[2]}), 16'(0));
        end

        // Freeze: ch3 high until accepted, then disable while the input drops.
        bus.x_in[3] = 1'b1;
        found = 1'b0;
        for (int j = 0; j < 20 && !found; j++) begin
            step("wait_y3");
            found = bus.y_out[3];
        end
        chk("wait_y3_timeout", 16'(found), 16'(1));
        bus.en = 1'b0; bus.x_in[3] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step("frozen");
            chk("frozen_y3", 16'({bus.y_out[3], bus.fall[3]}), 16'(2'b10));
        end
        bus.en = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            step("resume");
            if (j < 4)  chk("resume_early", 16'({bus.y_out[3], bus.fall[3]}), 16'(2'b10));
            if (j == 4) chk("resume_fall3", 16'({bus.y_out[3], bus.fall[3]}), 16'(2'b01));
        end

        // Asynchronous reset while all channels are high and mid-way to falling.
        bus.x_in = '1;
        found = 1'b0;
        for (int j = 0; j < 20 && !found; j++) begin
            step("wait_all");
            found = (bus.y_out == '1);
        end
        chk("wait_all_timeout", 16'(found), 16'(1));
        bus.x_in = '0;
        step("pre_rst");
        step("pre_rst");
        #2 rst = 1'b1;
        model_reset();
        #1 chk("async_rst", outs(), 16'(0));
        step("held_rst");
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            step("post_rst");
            chk("post_rst_nofall", 16'(bus.fall), 16'(0));
        end

        // Randomized: sparse toggles give both glitches and long runs; mode/en occasionally change.
        for (int j = 0; j < 400; j++) begin
            logic [CH-1:0] flip;
            for (int c = 0; c < int'(CH); c++) flip[c] = ($urandom_range(3) == 0);
            bus.x_in = bus.x_in ^ flip;
            if ($urandom_range(19) == 0) bus.mode = ~bus.mode;
            bus.en = ($urandom_range(9) != 0);
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/glitch_filter_multi.md
Name: glitch_filter_multi

Overview:
- Parametrised multi-channel successor to the team's single-bit deglitch filter.
- Synchronises each asynchronous input, keeps a DEPTH-sample history per channel, and drives a clean level with registered rise/fall strobes.
- Two run-time filter rules: unanimous (all samples agree) or majority (more than half agree).
- Sits between raw board inputs (comparator trips, switches, encoder lines) and the MPPT/control logic.

Parameters:
- CH, 4, number of independent channels (>=1).
- DEPTH, 4, history length in samples per channel (>=2).

Ports:
- cp  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  filter enable; 0 freezes history and outputs.
- mode  input  1  filter rule: 0 = unanimous, 1 = majority.
- x_in  input  CH  raw, possibly glitchy, asynchronous inputs.
- y_out  output  CH  filtered levels.
- rise  output  CH  one-cycle pulse when y_out[c] goes 0->1.
- fall  output  CH  one-cycle pulse when y_out[c] goes 1->0.
- unstable  output  CH  1 while channel c's history is not all-equal.

Behaviour:
- Reset (asynchronous, active-high): clear sync stages s1 and s2, history h, y_out, rise, fall and unstable to 0 immediately. On release, history starts from all-zero.
- Per channel c, every cp edge:
  - s1 <= x_in[c]; s2 <= s1. The sync stages run regardless of en.
  - If en=1: h <= {h[DEPTH-2:0], s2}. h[0] is the newest sample.
  - If en=0: h, y_out and unstable hold; rise and fall are 0.
- ones = population count of h, width clog2(DEPTH+1). Decision uses h as registered before the edge:
  - mode=0: all ones -> y=1; all zeros -> y=0; otherwise hold.
  - mode=1: 2*ones > DEPTH -> y=1; 2*ones < DEPTH -> y=0; tie (even DEPTH only) -> hold.
- Output registers:
  - y_out <= y.
  - rise <= (y=1 and y_out=0).
  - fall <= (y=0 and y_out=1).
  - rise and fall assert in the same cycle that y_out changes, for exactly one cycle, and are never both high.
- unstable <= h is neither all ones nor all zeros. It is registered and holds when en=0.
- Latency: x_in is sampled at edge k, and h[i] holds that sample after edge k+2+i.
  - mode=0: y_out changes after edge k+2+DEPTH (DEPTH=4 -> k+6).
  - mode=1: y_out changes after edge k+3+floor(DEPTH/2) (DEPTH=4 -> k+5).
- Rejection: in mode=0, any pulse shorter than DEPTH samples is rejected. In mode=1, any pulse of floor(DEPTH/2) samples or fewer is rejected.
- Mode change: takes effect at the next edge with no history flush. y_out only moves if the new rule decides a value different from the current one.
- en 0->1: history resumes shifting from its frozen contents. The pipeline is not refilled.
- Reset mid-operation: outputs go to 0 without a fall pulse. rise and fall never pulse on reset.
- Channels are fully independent. No cross-channel state.

Test Plan (CH=4, DEPTH=4, en=1 unless stated):
- Reset then x_in=4'b0000 held for 20 cycles -> y_out=0, rise=fall=unstable=0 throughout.
- mode=0, x_in[0] steps 0->1 at edge k -> y_out[0]=1 and rise[0]=1 for one cycle after edge k+6; unstable[0]=1 after edges k+3..k+5, then 0.
- mode=0, 3-cycle high pulse on x_in[1] -> y_out[1] stays 0, rise[1] never asserts, unstable[1] pulses. mode=1, same pulse -> y_out[1]=1 after edge k+5, then fall[1] after edge k+8.
- mode=1, 2-cycle high pulse on x_in[2] (tie case) -> y_out[2] stays 0, no rise or fall.
- x_in[3]=1 until y_out[3]=1, then en=0 and x_in[3]=0 for 10 cycles -> y_out[3] stays 1. After en=1 -> fall[3] on the 4th edge following re-enable.
- Assert rst while y_out=4'b1111 mid-transition -> all outputs read 0 before the next cp edge; no fall pulses.
